// File: rtl/pad_strip_pkg.sv
// pad_strip_pkg: shared sizing, command record and FSM states
// for the pad_strip control path.
package pad_strip_pkg;

    function automatic int log2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DATA_WIDTH = 128;
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int BYTE_W     = log2(DATA_BYTES);
    localparam int DATA_BCNT  = BYTE_W + 1;
    localparam int OFFS_W     = 16;
    localparam int TGT_W      = OFFS_W - BYTE_W;
    localparam int CMD_DEPTH  = 4;

    typedef struct packed {
        logic [TGT_W-1:0]     tgt_beat;
        logic [BYTE_W-1:0]    off;
        logic [DATA_BCNT-1:0] bcnt;
    } pad_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

endpackage

// File: rtl/pad_strip_ctrl_if.sv
// pad_strip_ctrl_if: command channel, upstream stream handshake
// and pad controls driven towards the pad_strip datapath.
interface pad_strip_ctrl_if;
    import pad_strip_pkg::*;

    logic                 cmd_vld;
    logic                 cmd_rdy;
    logic [OFFS_W-1:0]    cmd_offset;
    logic [DATA_BCNT-1:0] cmd_bcnt;
    logic                 data_in_vld;
    logic                 data_in_eop;
    logic                 data_out_rdy;
    logic                 data_in_rdy;
    logic                 data_pad_en;
    logic [DATA_BCNT-1:0] data_pad_offset;
    logic [DATA_BCNT-1:0] data_pad_bcnt;
    logic                 pad_miss;
    logic                 cmd_err;

    modport master (
        output cmd_vld, cmd_offset, cmd_bcnt,
        output data_in_vld, data_in_eop, data_out_rdy,
        input  cmd_rdy, data_in_rdy,
        input  data_pad_en, data_pad_offset, data_pad_bcnt,
        input  pad_miss, cmd_err
    );

    modport slave (
        input  cmd_vld, cmd_offset, cmd_bcnt,
        input  data_in_vld, data_in_eop, data_out_rdy,
        output cmd_rdy, data_in_rdy,
        output data_pad_en, data_pad_offset, data_pad_bcnt,
        output pad_miss, cmd_err
    );

endinterface

// File: rtl/pad_cmd_fifo.sv
// pad_cmd_fifo: synchronous FIFO of pad commands; pointers carry
// an extra wrap bit so full/empty need no separate counter.
module pad_cmd_fifo
    import pad_strip_pkg::*;
#(
    parameter int DEPTH = CMD_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  pad_cmd_t din,
    input  logic     pop,
    output pad_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = log2(DEPTH);

    pad_cmd_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // advance pointers on accepted push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // storage array, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pad_strip_ctrl.sv
// pad_strip_ctrl: per-packet pad sequencer beside pad_strip.
// Optional stats counters under `PAD_STRIP_CTRL_STAT_EN.
module pad_strip_ctrl
    import pad_strip_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    pad_strip_ctrl_if.slave  bus
`ifdef PAD_STRIP_CTRL_STAT_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      stat_pad_cnt,
    output logic [15:0]      stat_miss_cnt,
    output logic [15:0]      stat_err_cnt
`endif
);

    state_t               state;
    state_t               state_nx;
    pad_cmd_t             act;
    pad_cmd_t             fifo_dout;
    pad_cmd_t             new_cmd;
    logic [OFFS_W-1:0]    beat_cnt;
    logic [BYTE_W+1:0]    end_pos;
    logic                 acc;
    logic                 eop_acc;
    logic                 push_try;
    logic                 cmd_ok;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 load;
    logic                 hit;
    logic                 pad_en;
    logic                 miss_nx;
    logic                 miss_q;
    logic                 err_q;

    assign acc      = bus.data_in_vld & bus.data_out_rdy;
    assign eop_acc  = acc & bus.data_in_eop;
    assign push_try = bus.cmd_vld & ~fifo_full;
    assign end_pos  = (BYTE_W+2)'(bus.cmd_offset[BYTE_W-1:0]) +
                      (BYTE_W+2)'(bus.cmd_bcnt);
    assign cmd_ok   = (end_pos <= (BYTE_W+2)'(DATA_BYTES)) &&
                      (bus.cmd_bcnt != '0);

    assign new_cmd.tgt_beat = bus.cmd_offset[OFFS_W-1:BYTE_W];
    assign new_cmd.off      = bus.cmd_offset[BYTE_W-1:0];
    assign new_cmd.bcnt     = bus.cmd_bcnt;

    pad_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_try & cmd_ok),
        .din   (new_cmd),
        .pop   (load),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hit = (beat_cnt == {{BYTE_W{1'b0}}, act.tgt_beat});

    // next state; pops only at a packet boundary
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        miss_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                // never arm on a beat that is mid-packet
                if (!fifo_empty && beat_cnt == '0 &&
                    !(acc && !bus.data_in_eop)) begin
                    load     = 1'b1;
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (acc && hit && !bus.data_in_eop) begin
                    state_nx = DONE;
                end else if (eop_acc) begin
                    miss_nx  = ~hit;
                    load     = ~fifo_empty;
                    state_nx = fifo_empty ? IDLE : ARMED;
                end
            end
            DONE: begin
                if (eop_acc) begin
                    load     = ~fifo_empty;
                    state_nx = fifo_empty ? IDLE : ARMED;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // packet-relative beat counter, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (acc) begin
            if (bus.data_in_eop)     beat_cnt <= '0;
            else if (beat_cnt != '1) beat_cnt <= beat_cnt + OFFS_W'(1);
        end
    end

    // state, active command and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            act    <= '0;
            miss_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            miss_q <= miss_nx;
            err_q  <= push_try & ~cmd_ok;
            if (load) act <= fifo_dout;
        end
    end

    assign pad_en              = (state == ARMED) && hit;
    assign bus.cmd_rdy         = ~fifo_full;
    assign bus.data_in_rdy     = bus.data_out_rdy;
    assign bus.data_pad_en     = pad_en;
    assign bus.data_pad_offset = pad_en ? {1'b0, act.off} : '0;
    assign bus.data_pad_bcnt   = pad_en ? act.bcnt : '0;
    assign bus.pad_miss        = miss_q;
    assign bus.cmd_err         = err_q;

`ifdef PAD_STRIP_CTRL_STAT_EN
    // saturating event counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pad_cnt  <= '0;
            stat_miss_cnt <= '0;
            stat_err_cnt  <= '0;
        end else if (stat_clr) begin
            stat_pad_cnt  <= '0;
            stat_miss_cnt <= '0;
            stat_err_cnt  <= '0;
        end else begin
            if (pad_en && acc && stat_pad_cnt != '1)
                stat_pad_cnt <= stat_pad_cnt + 32'd1;
            if (miss_nx && stat_miss_cnt != '1)
                stat_miss_cnt <= stat_miss_cnt + 16'd1;
            if (push_try && !cmd_ok && stat_err_cnt != '1)
                stat_err_cnt <= stat_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pad_strip_ctrl.sv
// tb_pad_strip_ctrl: directed stimulus, queue-based reference
// model and a per-cycle compare of all pad_strip_ctrl outputs.
module tb_pad_strip_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pad_strip_ctrl_if bus();

    pad_strip_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int miss_seen = 0;
    int err_seen = 0;
    bit bp = 0;

    typedef struct {
        int tgt;
        int off;
        int bc;
    } mcmd_t;

    mcmd_t q[$];
    mcmd_t m_cur;
    mcmd_t nc;
    int    m_beat = 0;
    bit    m_act = 0;
    bit    m_done = 0;
    bit    m_miss = 0;
    bit    m_err = 0;
    bit    s_acc, s_eop, s_hit, s_clr, s_idle, s_try, s_ok;
    int    s_qn;
    int    e_en;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // reference model: one armed command per packet, queue of pending
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_beat = 0;
            m_act = 0;
            m_done = 0;
            m_miss = 0;
            m_err = 0;
        end else begin
            s_acc = bus.data_in_vld && bus.data_out_rdy;
            s_eop = bus.data_in_eop;
            s_qn = q.size();
            s_idle = !m_act;
            s_try = bus.cmd_vld && s_qn < 4;
            s_ok = ((int'(bus.cmd_offset) % 16) + int'(bus.cmd_bcnt) <= 16)
                   && bus.cmd_bcnt != 0;
            m_err = s_try && !s_ok;
            m_miss = 0;
            s_clr = 0;
            s_hit = 0;
            if (s_acc && m_act) begin
                s_hit = !m_done && m_beat == m_cur.tgt;
                if (s_hit && !s_eop) begin
                    m_done = 1;
                end else if (s_eop) begin
                    s_clr = 1;
                    m_miss = !s_hit && !m_done;
                    m_act = 0;
                end
            end
            if (s_qn > 0 && (s_clr ||
                (s_idle && m_beat == 0 && !(s_acc && !s_eop)))) begin
                m_cur = q.pop_front();
                m_act = 1;
                m_done = 0;
            end
            if (s_acc)
                m_beat = s_eop ? 0 : (m_beat < 65535 ? m_beat + 1 : m_beat);
            if (s_try && s_ok) begin
                nc.tgt = int'(bus.cmd_offset) / 16;
                nc.off = int'(bus.cmd_offset) % 16;
                nc.bc = int'(bus.cmd_bcnt);
                q.push_back(nc);
            end
        end
    end

    // compare every output against the model each cycle
    initial forever begin
        @(negedge clk);
        e_en = (m_act && !m_done && m_beat == m_cur.tgt) ? 1 : 0;
        chk("cmd_rdy", int'(bus.cmd_rdy), (q.size() < 4) ? 1 : 0);
        chk("in_rdy", int'(bus.data_in_rdy), int'(bus.data_out_rdy));
        chk("pad_en", int'(bus.data_pad_en), e_en);
        chk("pad_off", int'(bus.data_pad_offset), e_en ? m_cur.off : 0);
        chk("pad_bcnt", int'(bus.data_pad_bcnt), e_en ? m_cur.bc : 0);
        chk("pad_miss", int'(bus.pad_miss), int'(m_miss));
        chk("cmd_err", int'(bus.cmd_err), int'(m_err));
        if (bus.pad_miss) miss_seen++;
        if (bus.cmd_err) err_seen++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int off, input int bc);
        bus.cmd_vld = 1'b1;
        bus.cmd_offset = 16'(off);
        bus.cmd_bcnt = 5'(bc);
        step(1);
        bus.cmd_vld = 1'b0;
    endtask

    task automatic push_wait(input int off, input int bc);
        for (int k = 0; k < 16 && !bus.cmd_rdy; k++) step(1);
        if (!bus.cmd_rdy) chk("rdy_timeout", 0, 1);
        push(off, bc);
    endtask

    task automatic send_beat(input bit eop, input bit pen,
                             input int poff, input int pbc);
        bit done = 0;
        for (int k = 0; k < 16 && !done; k++) begin
            bus.data_in_vld = 1'b1;
            bus.data_in_eop = eop;
            bus.data_out_rdy = bp ? ~bus.data_out_rdy : 1'b1;
            @(negedge clk);
            if (bus.data_out_rdy) begin
                chk("lit_en", int'(bus.data_pad_en), int'(pen));
                chk("lit_off", int'(bus.data_pad_offset), poff);
                chk("lit_bcnt", int'(bus.data_pad_bcnt), pbc);
                done = 1;
            end
            @(posedge clk);
            #2;
        end
        if (!done) chk("beat_timeout", 0, 1);
        bus.data_in_vld = 1'b0;
        bus.data_in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int pb,
                            input int off, input int bc);
        for (int b = 0; b < n; b++)
            send_beat(b == n - 1, b == pb,
                      b == pb ? off : 0, b == pb ? bc : 0);
    endtask

    initial begin
        bus.cmd_vld = 1'b0;
        bus.cmd_offset = '0;
        bus.cmd_bcnt = '0;
        bus.data_in_vld = 1'b0;
        bus.data_in_eop = 1'b0;
        bus.data_out_rdy = 1'b1;
        #1;
        chk("rst_cmd_rdy", int'(bus.cmd_rdy), 1);
        chk("rst_pad_en", int'(bus.data_pad_en), 0);
        chk("rst_miss", int'(bus.pad_miss), 0);
        chk("rst_err", int'(bus.cmd_err), 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // single pad on beat 1
        push(20, 4);
        step(3);
        send_pkt(3, 1, 4, 4);
        step(2);

        // pad on the eop beat, then an unpadded packet
        push(32, 16);
        step(3);
        send_pkt(3, 2, 0, 16);
        step(2);
        send_pkt(2, -1, 0, 0);
        step(2);
        chk("t2_miss", miss_seen, 0);

        // target beyond eop
        push(64, 4);
        step(3);
        send_pkt(2, -1, 0, 0);
        step(2);
        chk("t3_miss", miss_seen, 1);
        send_pkt(1, -1, 0, 0);
        step(1);
        chk("t3_rdy", int'(bus.cmd_rdy), 1);

        // rejected commands
        push(14, 4);
        @(negedge clk);
        chk("t4_err_cross", int'(bus.cmd_err), 1);
        step(1);
        push(0, 0);
        @(negedge clk);
        chk("t4_err_zero", int'(bus.cmd_err), 1);
        step(1);
        push(3, 17);
        @(negedge clk);
        chk("t4_err_big", int'(bus.cmd_err), 1);
        step(2);
        chk("t4_err_cnt", err_seen, 3);
        send_pkt(1, -1, 0, 0);
        push(12, 4);
        step(3);
        send_pkt(1, 0, 12, 4);
        step(2);

        // fill FIFO while a packet is open, then backpressure
        send_beat(1'b0, 1'b0, 0, 0);
        push(0, 1);
        push(17, 2);
        push(40, 8);
        push(15, 1);
        chk("t5_full", int'(bus.cmd_rdy), 0);
        push(50, 3);
        send_beat(1'b1, 1'b0, 0, 0);
        push_wait(50, 3);
        step(2);
        bp = 1;
        send_pkt(4, 0, 0, 1);
        send_pkt(4, 1, 1, 2);
        send_pkt(4, 2, 8, 8);
        send_pkt(4, 0, 15, 1);
        send_pkt(4, 3, 2, 3);
        bp = 0;
        bus.data_out_rdy = 1'b1;
        step(2);
        chk("t5_rdy", int'(bus.cmd_rdy), 1);
        chk("t5_miss", miss_seen, 1);
        chk("t5_err", err_seen, 3);

        // async reset while armed on the target beat
        push(16, 4);
        step(3);
        send_beat(1'b0, 1'b0, 0, 0);
        chk("t6_en_armed", int'(bus.data_pad_en), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_en_rst", int'(bus.data_pad_en), 0);
        chk("t6_off_rst", int'(bus.data_pad_offset), 0);
        chk("t6_rdy_rst", int'(bus.cmd_rdy), 1);
        step(1);
        rst_n = 1'b1;
        step(2);
        send_pkt(2, -1, 0, 0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
